mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  RV32IM MEM stage. Directly downstream of the EX stage: it consumes the EX/MEM pipeline register outputs.
//  Runs loads/stores over a req/ack data-memory port and does byte/half alignment and sign/zero extension.
//  Stalls the pipeline while an access is outstanding, then registers its results into MEM/WB.
// PARAMETERS
//  TIMEOUT   64   wait-state cycles allowed before an access is aborted; 0 = wait forever
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  reg_write_in   in   1   EX/MEM: register-file write enable
//  pc_in          in   32  EX/MEM: instruction PC
//  alu_result_in  in   32  EX/MEM: ALU result / effective address
//  read_data2_in  in   32  EX/MEM: rs2 value (store data)
//  imm_in         in   32  EX/MEM: immediate
//  dest_addr_in   in   5   EX/MEM: rd
//  mem_read_in    in   4   [3]=load, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//  mem_write_in   in   3   [2]=store, [1:0]=size (00 B, 01 H, 10 W)
//  wb_sel_in      in   2   EX/MEM: writeback select (passed through)
//  dmem_req       out  1   memory request valid; held until dmem_ack
//  dmem_we        out  1   1 = store
//  dmem_addr      out  32  word address {alu_result_in[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
//  dmem_ack       in   1   request complete; dmem_rdata valid this cycle
//  dmem_rdata     in   32  read word
//  mem_stall      out  1   freezes PC, IF/ID, ID/EX and EX/MEM
//  reg_write_out, pc_out, alu_result_out, imm_out, dest_addr_out, wb_sel_out   out   MEM/WB copies
//  load_data_out  out  32  aligned, extended load result
//  bus_err_out    out  1   one-cycle pulse when an access times out
// BEHAVIOUR
//  - Reset (async, rst=0): FSM=IDLE; every output register 0; dmem_req=0 immediately; wait counter 0.
//  - FSM states: IDLE, WAIT. Access = mem_read_in[3] | mem_write_in[2]; both set is illegal, load wins.
//  - IDLE + access: dmem_req=1 combinationally. If dmem_ack=1 in the same cycle: complete, stay IDLE.
//    Otherwise go to WAIT.
//  - WAIT: hold req/we/addr/wdata/be stable. On ack: complete and go to IDLE.
//  - mem_stall = access & ~dmem_ack & ~abort. Upstream holds inputs stable while it is high.
//  - Complete/non-access edge: MEM/WB regs load the inputs. Non-access latency is 1 cycle.
//  - While stalled: MEM/WB loads a bubble (reg_write_out=0, dest_addr_out=0, wb_sel_out=0).
//  - Store formatting: SB wdata={4{rs2[7:0]}}, be=4'b0001<<a[1:0]. SH wdata={2{rs2[15:0]}}, be=a[1]?1100:0011.
//    SW wdata=rs2, be=1111. Loads use be=1111. Here a = alu_result_in.
//  - Load: byte/half selected by a[1:0]/a[1]; LB/LH sign-extend, LBU/LHU zero-extend. Stores give load_data_out=0.
//  - Timeout (TIMEOUT>0): counter counts WAIT cycles. When it reaches TIMEOUT:
//    drop req, go to IDLE, load a bubble, pulse bus_err_out, release stall.
//    A late ack arriving in IDLE with no request is ignored.
//  - Reset mid-access: request is abandoned with no bubble or error pulse; the memory must tolerate the drop.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, issues no request and no stall.
//    Next edge: bubble plus misalign_out=1 for one cycle. misalign_out is a 1-bit port that exists only under this macro.
//    alu_result_out carries the faulting address.
//  MISALIGN_TRAP_EN undefined: the low address bits the access size cannot use are ignored.
//    Word accesses are forced aligned; halves use a[1] only. No extra port.
// STRUCTURE
//  - Package mem_stage_defs: mem_read/mem_write encodings, size codes, FSM state codes.
//  - Sub-module load_store_align (combinational): store wdata/be generation, load extract/extend.
//  - FSM, timeout counter and MEM/WB register stay in this module.
// TESTING
//  1. SW a=0x100, rs2=0xDEADBEEF, ack after 2 waits -> mem_stall high 2 cycles, be=1111; regs update on the ack edge.
//  2. LB a=0x103, rdata=0x80FF_0000 -> load_data_out=0xFFFFFF80. LBU -> 0x00000080.
//     LH a=0x102 -> 0xFFFF80FF.
//  3. SB a=0x101, rs2=0x12 -> wdata=0x12121212, be=0010. ADD (no access) -> 1-cycle passthrough, no req.
//  4. TIMEOUT=4, ack never arrives -> 4 stall cycles, bus_err_out pulse, reg_write_out=0, req dropped.
//  5. Reset asserted in WAIT -> dmem_req=0 with no clock edge; outputs 0; next LW after reset completes normally.
//  6. MISALIGN_TRAP_EN, LW a=0x102 -> no req, misalign_out pulse, alu_result_out=0x102.
//     Without the macro -> dmem_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_stage_defs.sv
// rtl/mem_stage_defs.sv - shared encodings for the MEM stage (load funct3, access sizes, FSM states)
package mem_stage_defs;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Reserved size code 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - store lane replication/byte enables and load byte/half extract with extension
module load_store_align
    import mem_stage_defs::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  store_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        if (!is_load) begin
            case (store_size)
                SZ_B: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                SZ_H: begin
                    wdata = {2{store_data[15:0]}};
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata = store_data;
                    be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Undefined load funct3 codes fall back to a full-word load.
    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            F3_LW:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32IM MEM stage with req/ack data port, stall, timeout and MEM/WB register (option: MISALIGN_TRAP_EN)
module mem_access_stage
    import mem_stage_defs::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data2_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  dest_addr_in,
    input  logic [3:0]  mem_read_in,
    input  logic [2:0]  mem_write_in,
    input  logic [1:0]  wb_sel_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        reg_write_out,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] imm_out,
    output logic [4:0]  dest_addr_out,
    output logic [1:0]  wb_sel_out,
    output logic [31:0] load_data_out,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_out,
`endif
    output logic        bus_err_out
);

    localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic          is_load, is_store, misalign, access, abort;
    logic [31:0]   ld_data;

    assign is_load  = mem_read_in[3];
    assign is_store = mem_write_in[2] & ~mem_read_in[3];

`ifdef MISALIGN_TRAP_EN
    logic [1:0] acc_size;
    assign acc_size = is_load ? mem_read_in[1:0] : mem_write_in[1:0];
    assign misalign = (is_load | is_store) & is_misaligned(acc_size, alu_result_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign access = (is_load | is_store) & ~misalign;

    // Gating with rst drops the request the moment reset asserts, without waiting for a clock.
    assign dmem_req  = rst & access & ~abort;
    assign dmem_we   = dmem_req & is_store;
    assign dmem_addr = {alu_result_in[31:2], 2'b00};
    assign mem_stall = rst & access & ~dmem_ack & ~abort;

    load_store_align u_align (
        .is_load    (is_load),
        .funct3     (mem_read_in[2:0]),
        .store_size (mem_write_in[1:0]),
        .addr_lo    (alu_result_in[1:0]),
        .store_data (read_data2_in),
        .rdata      (dmem_rdata),
        .wdata      (dmem_wdata),
        .be         (dmem_be),
        .load_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // wait_cnt counts cycles spent with the request outstanding; the abort cycle itself drops req.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        abort       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && !dmem_ack) begin
                    state_nx    = ST_WAIT;
                    wait_cnt_nx = CW'(1);
                end
            end
            ST_WAIT: begin
                if ((TIMEOUT > 0) && (wait_cnt == TO_VAL)) begin
                    abort       = 1'b1;
                    state_nx    = ST_IDLE;
                    wait_cnt_nx = '0;
                end else if (dmem_ack) begin
                    state_nx    = ST_IDLE;
                    wait_cnt_nx = '0;
                end else if (TIMEOUT > 0) begin
                    wait_cnt_nx = wait_cnt + CW'(1);
                end
            end
            default: begin
                state_nx    = ST_IDLE;
                wait_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_out  <= 1'b0;
            pc_out         <= '0;
            alu_result_out <= '0;
            imm_out        <= '0;
            dest_addr_out  <= '0;
            wb_sel_out     <= '0;
            load_data_out  <= '0;
            bus_err_out    <= 1'b0;
        end else begin
            pc_out         <= pc_in;
            alu_result_out <= alu_result_in;
            imm_out        <= imm_in;
            bus_err_out    <= abort;
            if (mem_stall || abort || misalign) begin
                reg_write_out <= 1'b0;
                dest_addr_out <= '0;
                wb_sel_out    <= '0;
                load_data_out <= '0;
            end else begin
                reg_write_out <= reg_write_in;
                dest_addr_out <= dest_addr_in;
                wb_sel_out    <= wb_sel_in;
                load_data_out <= is_load ? ld_data : 32'h0;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_out <= 1'b0;
        else      misalign_out <= misalign;
    end
`endif

endmodule
